// File: rtl/pcm_pkg.sv
// Shared definitions for the 16-bit stereo PCM serial link (serializer and deserializer).
package pcm_pkg;

  localparam int PCM_WIDTH      = 16;
  localparam int PCM_FRAME_BITS = 32;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } pcm_rx_state_t;

  typedef logic [PCM_WIDTH-1:0] pcm_word_t;

endpackage

// File: rtl/pcm_lr_edge_detect.sv
// Holds the previous LR sample and flags rising/falling LR transitions on the current sample.
module pcm_lr_edge_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_lr,
  output logic o_rise,
  output logic o_fall
);

  logic r_lr_prev;

  // Previous LR resets high so a first LR=0 sample already reads as a falling edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lr_prev <= 1'b1;
    end else begin
      r_lr_prev <= i_lr;
    end
  end

  assign o_rise = i_lr & ~r_lr_prev;
  assign o_fall = ~i_lr & r_lr_prev;

endmodule

// File: rtl/pcm_deserializer.sv
// I2S-style stereo PCM receiver: aligns to LR edges and emits one left/right pair per frame.
// Optional saturating frame_error_count output is enabled with `define PCM_DESER_ERR_COUNT_EN.
module pcm_deserializer
  import pcm_pkg::*;
#(
  parameter int DATA_BITS = PCM_WIDTH,
  parameter int SLOT_BITS = PCM_FRAME_BITS / 2
) (
  input  logic                 bit_clock_in,
  input  logic                 rst_active_high,
  input  logic                 serial_data_in,
  input  logic                 LR_select_in,
  output logic [DATA_BITS-1:0] pcm_data_left,
  output logic [DATA_BITS-1:0] pcm_data_right,
  output logic                 pcm_data_valid,
  output logic                 locked,
  output logic                 frame_error
`ifdef PCM_DESER_ERR_COUNT_EN
  ,
  output logic [7:0]           frame_error_count
`endif
);

  localparam int CNT_W = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_BITS - 1);
  localparam logic [CNT_W:0]   DATA_LIM  = (CNT_W + 1)'(DATA_BITS);

  pcm_rx_state_t        r_state;
  pcm_rx_state_t        w_state_nxt;
  logic [CNT_W-1:0]     r_slot;
  logic [CNT_W-1:0]     w_slot_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_left_hold;
  logic [DATA_BITS-1:0] r_left;
  logic [DATA_BITS-1:0] r_right;
  logic                 r_valid;
  logic                 r_locked;
  logic                 r_err;

  logic                 w_lr_rise;
  logic                 w_lr_fall;
  logic                 w_slot_last;
  logic                 w_capture;
  logic [DATA_BITS-1:0] w_word;
  logic                 w_shift_en;
  logic                 w_hold_ld;
  logic                 w_valid;
  logic                 w_err;
  logic                 w_locked_nxt;

  pcm_lr_edge_detect u_lr_edge (
    .i_clk  (bit_clock_in),
    .i_rst  (rst_active_high),
    .i_lr   (LR_select_in),
    .o_rise (w_lr_rise),
    .o_fall (w_lr_fall)
  );

  assign w_slot_last = (r_slot == SLOT_LAST);
  assign w_capture   = ({1'b0, r_slot} < DATA_LIM);
  // Word as it stands after this sample; padding slots beyond DATA_BITS leave it untouched.
  assign w_word      = w_capture ? DATA_BITS'({r_shift, serial_data_in}) : r_shift;

  always_ff @(posedge bit_clock_in) begin
    if (rst_active_high) begin
      r_state <= SYNC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_slot_nxt   = r_slot + CNT_W'(1);
    w_shift_en   = 1'b0;
    w_hold_ld    = 1'b0;
    w_valid      = 1'b0;
    w_err        = 1'b0;
    w_locked_nxt = r_locked;
    case (r_state)
      SYNC: begin
        w_slot_nxt   = {CNT_W{1'b0}};
        w_locked_nxt = 1'b0;
        if (w_lr_fall) begin
          w_state_nxt = LEFT;
        end else begin
          w_state_nxt = SYNC;
        end
      end
      LEFT: begin
        w_shift_en = w_capture;
        if (w_slot_last) begin
          w_slot_nxt = {CNT_W{1'b0}};
          if (w_lr_rise) begin
            w_hold_ld    = 1'b1;
            w_locked_nxt = 1'b1;
            w_state_nxt  = RIGHT;
          end else begin
            w_err        = 1'b1;
            w_locked_nxt = 1'b0;
            w_state_nxt  = SYNC;
          end
        end else if (w_lr_rise || w_lr_fall) begin
          w_err        = 1'b1;
          w_locked_nxt = 1'b0;
          w_slot_nxt   = {CNT_W{1'b0}};
          if (w_lr_fall) begin
            w_state_nxt = LEFT;
          end else begin
            w_state_nxt = SYNC;
          end
        end else begin
          w_state_nxt = LEFT;
        end
      end
      RIGHT: begin
        w_shift_en = w_capture;
        if (w_slot_last) begin
          w_slot_nxt = {CNT_W{1'b0}};
          if (w_lr_fall) begin
            w_valid     = 1'b1;
            w_state_nxt = LEFT;
          end else begin
            w_err        = 1'b1;
            w_locked_nxt = 1'b0;
            w_state_nxt  = SYNC;
          end
        end else if (w_lr_rise || w_lr_fall) begin
          // An early falling edge is itself a legal frame start.
          w_err        = 1'b1;
          w_locked_nxt = 1'b0;
          w_slot_nxt   = {CNT_W{1'b0}};
          if (w_lr_fall) begin
            w_state_nxt = LEFT;
          end else begin
            w_state_nxt = SYNC;
          end
        end else begin
          w_state_nxt = RIGHT;
        end
      end
      default: begin
        w_slot_nxt   = {CNT_W{1'b0}};
        w_locked_nxt = 1'b0;
        w_state_nxt  = SYNC;
      end
    endcase
  end

  always_ff @(posedge bit_clock_in) begin
    if (rst_active_high) begin
      r_slot      <= {CNT_W{1'b0}};
      r_shift     <= {DATA_BITS{1'b0}};
      r_left_hold <= {DATA_BITS{1'b0}};
      r_left      <= {DATA_BITS{1'b0}};
      r_right     <= {DATA_BITS{1'b0}};
      r_valid     <= 1'b0;
      r_locked    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_slot   <= w_slot_nxt;
      r_valid  <= w_valid;
      r_locked <= w_locked_nxt;
      r_err    <= w_err;
      if (w_shift_en) begin
        r_shift <= w_word;
      end
      if (w_hold_ld) begin
        r_left_hold <= w_word;
      end
      // Left and right are published together so the pair never tears mid-frame.
      if (w_valid) begin
        r_left  <= r_left_hold;
        r_right <= w_word;
      end
    end
  end

  assign pcm_data_left  = r_left;
  assign pcm_data_right = r_right;
  assign pcm_data_valid = r_valid;
  assign locked         = r_locked;
  assign frame_error    = r_err;

`ifdef PCM_DESER_ERR_COUNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge bit_clock_in) begin
    if (rst_active_high) begin
      r_err_cnt <= 8'd0;
    end else if (w_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign frame_error_count = r_err_cnt;
`endif

endmodule

// File: tb/tb_pcm_deserializer.sv
// Directed self-checking bench for pcm_deserializer (16-bit words, 16-bit slots).
`timescale 1ns/1ps
module tb_pcm_deserializer;
  import pcm_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  logic      sd;
  logic      lr;
  pcm_word_t pcm_left;
  pcm_word_t pcm_right;
  logic      valid;
  logic      lock;
  logic      ferr;
`ifdef PCM_DESER_ERR_COUNT_EN
  logic [7:0] ecnt;
`endif

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_err = 0;
  int valid_cyc = 0;
  int prev_valid_cyc = 0;

  always #5 clk = ~clk;

  pcm_deserializer dut (
    .bit_clock_in     (clk),
    .rst_active_high  (rst),
    .serial_data_in   (sd),
    .LR_select_in     (lr),
    .pcm_data_left    (pcm_left),
    .pcm_data_right   (pcm_right),
    .pcm_data_valid   (valid),
    .locked           (lock),
    .frame_error      (ferr)
`ifdef PCM_DESER_ERR_COUNT_EN
    ,
    .frame_error_count(ecnt)
`endif
  );

  task automatic send_bit(input logic l, input logic d);
    @(negedge clk);
    rst = 1'b0;
    lr  = l;
    sd  = d;
    @(posedge clk);
    #1;
    cyc++;
    if (valid === 1'b1) begin
      n_valid++;
      prev_valid_cyc = valid_cyc;
      valid_cyc = cyc;
    end
    if (ferr === 1'b1) n_err++;
  endtask

  // I2S framing: LR leads the data by one bit, so it flips on the last bit of each channel.
  task automatic send_frame_bits(input logic [15:0] l_word, input logic [15:0] r_word,
                                 input int first, input int last);
    for (int i = first; i <= last; i++) begin
      logic b;
      logic l;
      if (i < 16) b = l_word[15-i];
      else        b = r_word[31-i];
      if (i < 15)      l = 1'b0;
      else if (i < 31) l = 1'b1;
      else             l = 1'b0;
      send_bit(l, b);
    end
  endtask

  task automatic apply_reset(input logic l, input int ncyc);
    @(negedge clk);
    rst = 1'b1;
    lr  = l;
    sd  = 1'b0;
    repeat (ncyc) @(posedge clk);
    #1;
    n_valid = 0;
    n_err   = 0;
  endtask

  task automatic test_reset();
    apply_reset(1'b0, 2);
    n_cmp++; if (pcm_left !== 16'h0000) begin n_mis++; $display("FAIL reset_left got=%h want=0000", pcm_left); end
    n_cmp++; if (pcm_right !== 16'h0000) begin n_mis++; $display("FAIL reset_right got=%h want=0000", pcm_right); end
    n_cmp++; if (valid !== 1'b0) begin n_mis++; $display("FAIL reset_valid got=%b want=0", valid); end
    n_cmp++; if (lock !== 1'b0) begin n_mis++; $display("FAIL reset_locked got=%b want=0", lock); end
    n_cmp++; if (ferr !== 1'b0) begin n_mis++; $display("FAIL reset_ferr got=%b want=0", ferr); end
`ifdef PCM_DESER_ERR_COUNT_EN
    n_cmp++; if (ecnt !== 8'd0) begin n_mis++; $display("FAIL reset_ecnt got=%0d want=0", ecnt); end
`endif
  endtask

  task automatic test_basic();
    send_bit(1'b0, 1'b0);
    send_frame_bits(16'hA55A, 16'h1234, 0, 31);
    n_cmp++; if (valid !== 1'b1) begin n_mis++; $display("FAIL basic_valid_latency got=%b want=1", valid); end
    n_cmp++; if (lock !== 1'b1) begin n_mis++; $display("FAIL basic_locked got=%b want=1", lock); end
    n_cmp++; if (pcm_left !== 16'hA55A) begin n_mis++; $display("FAIL basic_left got=%h want=a55a", pcm_left); end
    n_cmp++; if (pcm_right !== 16'h1234) begin n_mis++; $display("FAIL basic_right got=%h want=1234", pcm_right); end
    send_frame_bits(16'hA55A, 16'h1234, 0, 31);
    send_frame_bits(16'hA55A, 16'h1234, 0, 31);
    n_cmp++; if (n_valid !== 3) begin n_mis++; $display("FAIL basic_valid_count got=%0d want=3", n_valid); end
    n_cmp++; if ((valid_cyc - prev_valid_cyc) !== 32) begin n_mis++; $display("FAIL basic_valid_spacing got=%0d want=32", valid_cyc - prev_valid_cyc); end
    n_cmp++; if (n_err !== 0) begin n_mis++; $display("FAIL basic_errors got=%0d want=0", n_err); end
  endtask

  task automatic test_back_to_back();
    send_frame_bits(16'h8000, 16'h7FFF, 0, 31);
    n_cmp++; if (pcm_left !== 16'h8000 || pcm_right !== 16'h7FFF) begin n_mis++; $display("FAIL b2b_pair1 got=%h/%h want=8000/7fff", pcm_left, pcm_right); end
    send_frame_bits(16'hFFFF, 16'h0001, 0, 19);
    n_cmp++; if (valid !== 1'b0) begin n_mis++; $display("FAIL b2b_midframe_valid got=%b want=0", valid); end
    n_cmp++; if (pcm_left !== 16'h8000 || pcm_right !== 16'h7FFF) begin n_mis++; $display("FAIL b2b_midframe_hold got=%h/%h want=8000/7fff", pcm_left, pcm_right); end
    send_frame_bits(16'hFFFF, 16'h0001, 20, 31);
    n_cmp++; if (valid !== 1'b1) begin n_mis++; $display("FAIL b2b_pair2_valid got=%b want=1", valid); end
    n_cmp++; if (pcm_left !== 16'hFFFF || pcm_right !== 16'h0001) begin n_mis++; $display("FAIL b2b_pair2 got=%h/%h want=ffff/0001", pcm_left, pcm_right); end
    n_cmp++; if (n_err !== 0) begin n_mis++; $display("FAIL b2b_errors got=%0d want=0", n_err); end
  endtask

  task automatic test_misalign();
    int v0;
    int e0;
    v0 = n_valid;
    e0 = n_err;
    // bit 25 is right slot 9; drop LR there instead of at bit 31
    send_frame_bits(16'hC3C3, 16'h5AA5, 0, 24);
    send_bit(1'b0, 1'b1);
    n_cmp++; if (ferr !== 1'b1) begin n_mis++; $display("FAIL mis_early_ferr got=%b want=1", ferr); end
    n_cmp++; if (lock !== 1'b0) begin n_mis++; $display("FAIL mis_early_locked got=%b want=0", lock); end
    send_frame_bits(16'h0F0F, 16'hF0F0, 0, 0);
    n_cmp++; if (ferr !== 1'b0) begin n_mis++; $display("FAIL mis_ferr_one_cycle got=%b want=0", ferr); end
    send_frame_bits(16'h0F0F, 16'hF0F0, 1, 31);
    n_cmp++; if (valid !== 1'b1) begin n_mis++; $display("FAIL mis_resume_valid got=%b want=1", valid); end
    n_cmp++; if (pcm_left !== 16'h0F0F || pcm_right !== 16'hF0F0) begin n_mis++; $display("FAIL mis_resume_pair got=%h/%h want=0f0f/f0f0", pcm_left, pcm_right); end
    n_cmp++; if ((n_valid - v0) !== 1) begin n_mis++; $display("FAIL mis_valid_count got=%0d want=1", n_valid - v0); end
    // Missing rise at the end of the left slot
    send_frame_bits(16'h1111, 16'h2222, 0, 14);
    send_bit(1'b0, 1'b1);
    n_cmp++; if (ferr !== 1'b1 || lock !== 1'b0) begin n_mis++; $display("FAIL mis_norise got=ferr%b/lock%b want=1/0", ferr, lock); end
    repeat (5) send_bit(1'b1, 1'b0);
    n_cmp++; if ((n_err - e0) !== 2) begin n_mis++; $display("FAIL mis_sync_ignores_rise got=%0d want=2", n_err - e0); end
    send_bit(1'b0, 1'b0);
    send_frame_bits(16'h6666, 16'h9999, 0, 31);
    n_cmp++; if (valid !== 1'b1 || pcm_left !== 16'h6666 || pcm_right !== 16'h9999) begin n_mis++; $display("FAIL mis_resync_pair got=%b %h/%h want=1 6666/9999", valid, pcm_left, pcm_right); end
  endtask

  task automatic test_mid_right();
    int fall_cyc;
    apply_reset(1'b1, 2);
    for (int i = 0; i < 10; i++) send_bit(1'b1, i[0]);
    n_cmp++; if (n_valid !== 0 || n_err !== 0) begin n_mis++; $display("FAIL midr_quiet got=%0d/%0d want=0/0", n_valid, n_err); end
    n_cmp++; if (lock !== 1'b0) begin n_mis++; $display("FAIL midr_locked got=%b want=0", lock); end
    send_bit(1'b0, 1'b0);
    fall_cyc = cyc;
    send_frame_bits(16'hABCD, 16'h4321, 0, 31);
    n_cmp++; if (n_valid !== 1) begin n_mis++; $display("FAIL midr_valid_count got=%0d want=1", n_valid); end
    n_cmp++; if ((valid_cyc - fall_cyc) !== 32) begin n_mis++; $display("FAIL midr_latency got=%0d want=32", valid_cyc - fall_cyc); end
    n_cmp++; if (pcm_left !== 16'hABCD || pcm_right !== 16'h4321) begin n_mis++; $display("FAIL midr_pair got=%h/%h want=abcd/4321", pcm_left, pcm_right); end
  endtask

  task automatic test_reset_mid();
    send_frame_bits(16'h1357, 16'h2468, 0, 7);
    apply_reset(1'b0, 1);
    n_cmp++; if (pcm_left !== 16'h0000 || pcm_right !== 16'h0000) begin n_mis++; $display("FAIL rmid_data got=%h/%h want=0000/0000", pcm_left, pcm_right); end
    n_cmp++; if (valid !== 1'b0 || lock !== 1'b0 || ferr !== 1'b0) begin n_mis++; $display("FAIL rmid_flags got=%b%b%b want=000", valid, lock, ferr); end
    send_bit(1'b0, 1'b0);
    send_frame_bits(16'h2468, 16'h1357, 0, 31);
    n_cmp++; if (valid !== 1'b1 || lock !== 1'b1) begin n_mis++; $display("FAIL rmid_recover got=v%b/l%b want=1/1", valid, lock); end
    n_cmp++; if (pcm_left !== 16'h2468 || pcm_right !== 16'h1357) begin n_mis++; $display("FAIL rmid_pair got=%h/%h want=2468/1357", pcm_left, pcm_right); end
  endtask

`ifdef PCM_DESER_ERR_COUNT_EN
  task automatic test_err_count();
    apply_reset(1'b1, 1);
    for (int i = 0; i < 200; i++) begin
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
    end
    n_cmp++; if (ecnt !== 8'd200) begin n_mis++; $display("FAIL ecnt_200 got=%0d want=200", ecnt); end
    for (int i = 0; i < 100; i++) begin
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
    end
    n_cmp++; if (n_err !== 300) begin n_mis++; $display("FAIL ecnt_pulses got=%0d want=300", n_err); end
    n_cmp++; if (ecnt !== 8'd255) begin n_mis++; $display("FAIL ecnt_saturate got=%0d want=255", ecnt); end
    apply_reset(1'b0, 1);
    n_cmp++; if (ecnt !== 8'd0) begin n_mis++; $display("FAIL ecnt_clear got=%0d want=0", ecnt); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    lr  = 1'b0;
    sd  = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_misalign();
    test_mid_right();
    test_reset_mid();
`ifdef PCM_DESER_ERR_COUNT_EN
    test_err_count();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
